// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_pkg
// Brief  : Shared constants and types for the MIPS fetch datapath.
// Rev    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0]  OPCODE_HALT = 6'b111111;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam int unsigned PC_INC      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    function automatic logic is_halt(input logic [5:0] opcode);
        return (opcode == OPCODE_HALT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_memory.sv
`default_nettype none
// ============================================================================
// Module : instruction_memory
// Brief  : Word-addressed instruction store, one async read, one sync write.
// Rev    : 1.0 - initial release
// ============================================================================
module instruction_memory #(
    parameter int N_BITS      = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int N_BITS_ADDR = 8
) (
    input  logic                   i_clk,
    input  logic                   i_wr_en,
    input  logic [N_BITS_ADDR-1:0] i_wr_addr,
    input  logic [N_BITS-1:0]      i_wr_data,
    input  logic [N_BITS_ADDR-1:0] i_rd_addr,
    output logic [N_BITS-1:0]      o_rd_data
);

    // No reset: program image must survive a stage reset.
    logic [N_BITS-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_stage
// Brief  : MIPS IF stage with PC, instruction memory, redirects and IF/ID reg.
// Rev    : 1.0 - initial release
// ============================================================================
module instr_fetch_stage
    import mips_pkg::*;
#(
    parameter int N_BITS      = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int N_BITS_ADDR = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_enable,
    input  logic                   i_stall,
    input  logic                   i_flush,
    input  logic                   i_jump,
    input  logic [N_BITS-1:0]      i_jump_target,
    input  logic                   i_branch_taken,
    input  logic [N_BITS-1:0]      i_branch_target,
    input  logic                   i_mem_wr_en,
    input  logic [N_BITS_ADDR-1:0] i_mem_wr_addr,
    input  logic [N_BITS-1:0]      i_mem_wr_data,
    output logic [N_BITS-1:0]      o_instruccion,
    output logic [N_BITS-1:0]      o_pc,
    output logic [N_BITS-1:0]      o_pc_next,
    output logic                   o_valid,
    output logic                   o_halted
);

    localparam logic [N_BITS-1:0] BUBBLE_INSTR = N_BITS'(NOP_INSTR);
    localparam logic [N_BITS-1:0] PC_STEP      = N_BITS'(PC_INC);

    fetch_state_e      state_q, state_d;
    logic [N_BITS-1:0] pc_q, pc_d;
    logic [N_BITS-1:0] instr_q, instr_d;
    logic [N_BITS-1:0] ifid_pc_q, ifid_pc_d;
    logic [N_BITS-1:0] ifid_pcn_q, ifid_pcn_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;

    logic [N_BITS-1:0] mem_rdata;
    logic [N_BITS-1:0] pc_plus4;
    logic              mem_we;
    logic              fetch_is_halt;

    // Loader may only touch the program while nothing is being fetched.
    assign mem_we = i_mem_wr_en && (state_q == IDLE);

    instruction_memory #(
        .N_BITS      (N_BITS),
        .MEM_DEPTH   (MEM_DEPTH),
        .N_BITS_ADDR (N_BITS_ADDR)
    ) u_imem (
        .i_clk     (i_clk),
        .i_wr_en   (mem_we),
        .i_wr_addr (i_mem_wr_addr),
        .i_wr_data (i_mem_wr_data),
        .i_rd_addr (pc_q[N_BITS_ADDR+1:2]),
        .o_rd_data (mem_rdata)
    );

    assign pc_plus4      = pc_q + PC_STEP;
    assign fetch_is_halt = is_halt(mem_rdata[N_BITS-1 -: 6]);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            ifid_pc_q  <= '0;
            ifid_pcn_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            ifid_pc_q  <= ifid_pc_d;
            ifid_pcn_q <= ifid_pcn_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
        end
    end

    // Bubbles clear only instruction/valid; o_pc/o_pc_next keep their values.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        ifid_pc_d  = ifid_pc_q;
        ifid_pcn_d = ifid_pcn_q;
        valid_d    = valid_q;
        halted_d   = halted_q;

        unique case (state_q)
            IDLE: begin
                instr_d = BUBBLE_INSTR;
                valid_d = 1'b0;
                if (i_start) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (!i_enable) begin
                    state_d = state_q;
                end else if (i_jump) begin
                    pc_d    = i_jump_target;
                    instr_d = BUBBLE_INSTR;
                    valid_d = 1'b0;
                end else if (i_branch_taken) begin
                    pc_d    = i_branch_target;
                    instr_d = BUBBLE_INSTR;
                    valid_d = 1'b0;
                end else if (i_flush) begin
                    pc_d    = pc_plus4;
                    instr_d = BUBBLE_INSTR;
                    valid_d = 1'b0;
                end else if (i_stall) begin
                    state_d = state_q;
                end else begin
                    instr_d    = mem_rdata;
                    ifid_pc_d  = pc_q;
                    ifid_pcn_d = pc_plus4;
                    valid_d    = 1'b1;
                    // HALT is delivered downstream once, then the PC freezes on it.
                    if (fetch_is_halt) begin
                        state_d = HALTED;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end

            HALTED: begin
                instr_d  = BUBBLE_INSTR;
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end

            default: begin
                state_d = IDLE;
                instr_d = BUBBLE_INSTR;
                valid_d = 1'b0;
            end
        endcase
    end

    assign o_instruccion = instr_q;
    assign o_pc          = ifid_pc_q;
    assign o_pc_next     = ifid_pcn_q;
    assign o_valid       = valid_q;
    assign o_halted      = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_fetch_stage
// Brief  : Scenario bench for instr_fetch_stage with an expected-output queue.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_stage;

    localparam int N_BITS      = 32;
    localparam int MEM_DEPTH   = 256;
    localparam int N_BITS_ADDR = 8;

    logic                   i_clk = 1'b0;
    logic                   i_reset;
    logic                   i_start, i_enable, i_stall, i_flush;
    logic                   i_jump, i_branch_taken;
    logic [N_BITS-1:0]      i_jump_target, i_branch_target;
    logic                   i_mem_wr_en;
    logic [N_BITS_ADDR-1:0] i_mem_wr_addr;
    logic [N_BITS-1:0]      i_mem_wr_data;
    logic [N_BITS-1:0]      o_instruccion, o_pc, o_pc_next;
    logic                   o_valid, o_halted;

    instr_fetch_stage #(
        .N_BITS      (N_BITS),
        .MEM_DEPTH   (MEM_DEPTH),
        .N_BITS_ADDR (N_BITS_ADDR)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_start         (i_start),
        .i_enable        (i_enable),
        .i_stall         (i_stall),
        .i_flush         (i_flush),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_mem_wr_en     (i_mem_wr_en),
        .i_mem_wr_addr   (i_mem_wr_addr),
        .i_mem_wr_data   (i_mem_wr_data),
        .o_instruccion   (o_instruccion),
        .o_pc            (o_pc),
        .o_pc_next       (o_pc_next),
        .o_valid         (o_valid),
        .o_halted        (o_halted)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcn;
        logic        valid;
        logic        halted;
    } ifid_t;

    typedef enum int {
        OP_NONE, OP_START, OP_JUMP, OP_BR, OP_JB, OP_FLUSH,
        OP_FS, OP_STALL, OP_DIS, OP_WR
    } op_e;

    typedef struct {
        op_e         op;
        logic [31:0] tgt;
        ifid_t       e;
    } vec_t;

    ifid_t       sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] bmem [MEM_DEPTH];

    function automatic ifid_t E(input logic [31:0] ins, input logic [31:0] pc,
                                input logic [31:0] pcn, input logic v, input logic h);
        return {ins, pc, pcn, v, h};
    endfunction

    function automatic ifid_t cur();
        return {o_instruccion, o_pc, o_pc_next, o_valid, o_halted};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input op_e op, input logic [31:0] tgt);
        i_start = 0; i_enable = 1; i_stall = 0; i_flush = 0;
        i_jump = 0; i_jump_target = 0; i_branch_taken = 0; i_branch_target = 0;
        i_mem_wr_en = 0; i_mem_wr_addr = 0; i_mem_wr_data = 0;
        case (op)
            OP_START: i_start = 1;
            OP_JUMP:  begin i_jump = 1; i_jump_target = tgt; end
            OP_BR:    begin i_branch_taken = 1; i_branch_target = tgt; end
            OP_JB:    begin i_jump = 1; i_jump_target = tgt;
                            i_branch_taken = 1; i_branch_target = 32'h40; end
            OP_FLUSH: i_flush = 1;
            OP_FS:    begin i_flush = 1; i_stall = 1; end
            OP_STALL: i_stall = 1;
            OP_DIS:   begin i_enable = 0; i_jump = 1; i_jump_target = 32'h80; end
            OP_WR:    begin i_mem_wr_en = 1; i_mem_wr_addr = tgt[7:0];
                            i_mem_wr_data = 32'hDEAD_BEEF; end
            default:  ;
        endcase
    endtask

    task automatic write_word(input int idx, input logic [31:0] data);
        drive(OP_NONE, 0);
        i_mem_wr_en   = 1;
        i_mem_wr_addr = idx[7:0];
        i_mem_wr_data = data;
        bmem[idx]     = data;
        tick();
        i_mem_wr_en   = 0;
    endtask

    task automatic pulse_reset();
        @(negedge i_clk);
        i_reset = 0;
        tick();
        i_reset = 1;
    endtask

    task automatic test_reset();
        ifid_t e;
        e = E(0, 0, 0, 0, 0);
        n_cmp++;
        if (cur() !== e) begin
            n_err++; $display("FAIL reset_hold got=%h exp=%h", cur(), e);
        end
        i_reset = 1;
        drive(OP_NONE, 0); sb.push_back(e); tick();
        e = sb.pop_front(); n_cmp++;
        if (cur() !== e) begin
            n_err++; $display("FAIL reset_release got=%h exp=%h", cur(), e);
        end
    endtask

    task automatic test_load();
        ifid_t e;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            case (i)
                0:       write_word(i, 32'h2001_0005);
                1:       write_word(i, 32'h2002_0007);
                2:       write_word(i, 32'hFC00_0000);
                200:     write_word(i, 32'hFC00_0000);
                default: write_word(i, 32'h2000_0000 | i);
            endcase
        end
        drive(OP_NONE, 0); sb.push_back(E(0, 0, 0, 0, 0)); tick();
        e = sb.pop_front(); n_cmp++;
        if (cur() !== e) begin
            n_err++; $display("FAIL idle_after_load got=%h exp=%h", cur(), e);
        end
    endtask

    task automatic test_halt_program();
        vec_t v[$];
        ifid_t e;
        v.push_back(vec_t'{OP_START, 32'h0,  E(0, 0, 0, 0, 0)});
        v.push_back(vec_t'{OP_NONE,  32'h0,  E(32'h2001_0005, 0, 4, 1, 0)});
        v.push_back(vec_t'{OP_NONE,  32'h0,  E(32'h2002_0007, 4, 8, 1, 0)});
        v.push_back(vec_t'{OP_NONE,  32'h0,  E(32'hFC00_0000, 8, 32'hC, 1, 0)});
        v.push_back(vec_t'{OP_NONE,  32'h0,  E(0, 8, 32'hC, 0, 1)});
        v.push_back(vec_t'{OP_JUMP,  32'h40, E(0, 8, 32'hC, 0, 1)});
        v.push_back(vec_t'{OP_START, 32'h0,  E(0, 8, 32'hC, 0, 1)});
        for (int k = 0; k < v.size(); k++) begin
            drive(v[k].op, v[k].tgt); sb.push_back(v[k].e); tick();
            e = sb.pop_front(); n_cmp++;
            if (cur() !== e) begin
                n_err++; $display("FAIL halt[%0d] got=%h exp=%h", k, cur(), e);
            end
        end
    endtask

    task automatic test_branch();
        vec_t v[$];
        ifid_t e;
        v.push_back(vec_t'{OP_START, 32'h0,  E(0, 0, 0, 0, 0)});
        v.push_back(vec_t'{OP_NONE,  32'h0,  E(bmem[0], 0, 4, 1, 0)});
        v.push_back(vec_t'{OP_NONE,  32'h0,  E(bmem[1], 4, 8, 1, 0)});
        v.push_back(vec_t'{OP_NONE,  32'h0,  E(bmem[2], 8, 32'hC, 1, 0)});
        v.push_back(vec_t'{OP_NONE,  32'h0,  E(bmem[3], 32'hC, 32'h10, 1, 0)});
        v.push_back(vec_t'{OP_BR,    32'h40, E(0, 32'hC, 32'h10, 0, 0)});
        v.push_back(vec_t'{OP_NONE,  32'h0,  E(bmem[16], 32'h40, 32'h44, 1, 0)});
        for (int k = 0; k < v.size(); k++) begin
            drive(v[k].op, v[k].tgt); sb.push_back(v[k].e); tick();
            e = sb.pop_front(); n_cmp++;
            if (cur() !== e) begin
                n_err++; $display("FAIL branch[%0d] got=%h exp=%h", k, cur(), e);
            end
        end
    endtask

    task automatic test_jump_vs_branch();
        vec_t v[$];
        ifid_t e;
        v.push_back(vec_t'{OP_JB,   32'h80, E(0, 32'h40, 32'h44, 0, 0)});
        v.push_back(vec_t'{OP_NONE, 32'h0,  E(bmem[32], 32'h80, 32'h84, 1, 0)});
        for (int k = 0; k < v.size(); k++) begin
            drive(v[k].op, v[k].tgt); sb.push_back(v[k].e); tick();
            e = sb.pop_front(); n_cmp++;
            if (cur() !== e) begin
                n_err++; $display("FAIL jump_vs_branch[%0d] got=%h exp=%h", k, cur(), e);
            end
        end
    endtask

    task automatic test_stall();
        vec_t v[$];
        ifid_t e;
        v.push_back(vec_t'{OP_JUMP, 32'h8, E(0, 32'h80, 32'h84, 0, 0)});
        v.push_back(vec_t'{OP_NONE, 32'h0, E(bmem[2], 8, 32'hC, 1, 0)});
        for (int r = 0; r < 3; r++)
            v.push_back(vec_t'{OP_STALL, 32'h0, E(bmem[2], 8, 32'hC, 1, 0)});
        v.push_back(vec_t'{OP_NONE, 32'h0, E(bmem[3], 32'hC, 32'h10, 1, 0)});
        for (int r = 0; r < 3; r++)
            v.push_back(vec_t'{OP_DIS, 32'h0, E(bmem[3], 32'hC, 32'h10, 1, 0)});
        v.push_back(vec_t'{OP_NONE,  32'h0, E(bmem[4], 32'h10, 32'h14, 1, 0)});
        v.push_back(vec_t'{OP_FLUSH, 32'h0, E(0, 32'h10, 32'h14, 0, 0)});
        v.push_back(vec_t'{OP_FS,    32'h0, E(0, 32'h10, 32'h14, 0, 0)});
        v.push_back(vec_t'{OP_NONE,  32'h0, E(bmem[7], 32'h1C, 32'h20, 1, 0)});
        for (int k = 0; k < v.size(); k++) begin
            drive(v[k].op, v[k].tgt); sb.push_back(v[k].e); tick();
            e = sb.pop_front(); n_cmp++;
            if (cur() !== e) begin
                n_err++; $display("FAIL stall[%0d] got=%h exp=%h", k, cur(), e);
            end
        end
    endtask

    task automatic test_redirect_vs_halt();
        vec_t v[$];
        ifid_t e;
        v.push_back(vec_t'{OP_JUMP, 32'h31C, E(0, 32'h1C, 32'h20, 0, 0)});
        v.push_back(vec_t'{OP_NONE, 32'h0,   E(bmem[199], 32'h31C, 32'h320, 1, 0)});
        v.push_back(vec_t'{OP_BR,   32'h40,  E(0, 32'h31C, 32'h320, 0, 0)});
        v.push_back(vec_t'{OP_NONE, 32'h0,   E(bmem[16], 32'h40, 32'h44, 1, 0)});
        for (int k = 0; k < v.size(); k++) begin
            drive(v[k].op, v[k].tgt); sb.push_back(v[k].e); tick();
            e = sb.pop_front(); n_cmp++;
            if (cur() !== e) begin
                n_err++; $display("FAIL redirect_halt[%0d] got=%h exp=%h", k, cur(), e);
            end
        end
    endtask

    task automatic test_wrap();
        vec_t v[$];
        ifid_t e;
        v.push_back(vec_t'{OP_JUMP, 32'h3FC, E(0, 32'h40, 32'h44, 0, 0)});
        v.push_back(vec_t'{OP_WR,   32'h2,   E(bmem[255], 32'h3FC, 32'h400, 1, 0)});
        v.push_back(vec_t'{OP_WR,   32'h2,   E(bmem[0], 32'h400, 32'h404, 1, 0)});
        v.push_back(vec_t'{OP_NONE, 32'h0,   E(bmem[1], 32'h404, 32'h408, 1, 0)});
        v.push_back(vec_t'{OP_NONE, 32'h0,   E(bmem[2], 32'h408, 32'h40C, 1, 0)});
        v.push_back(vec_t'{OP_JUMP, 32'hFFFF_FFFC, E(0, 32'h408, 32'h40C, 0, 0)});
        v.push_back(vec_t'{OP_NONE, 32'h0,   E(bmem[255], 32'hFFFF_FFFC, 32'h0, 1, 0)});
        v.push_back(vec_t'{OP_NONE, 32'h0,   E(bmem[0], 32'h0, 32'h4, 1, 0)});
        v.push_back(vec_t'{OP_JUMP, 32'hB,   E(0, 32'h0, 32'h4, 0, 0)});
        v.push_back(vec_t'{OP_NONE, 32'h0,   E(bmem[2], 32'hB, 32'hF, 1, 0)});
        for (int k = 0; k < v.size(); k++) begin
            drive(v[k].op, v[k].tgt); sb.push_back(v[k].e); tick();
            e = sb.pop_front(); n_cmp++;
            if (cur() !== e) begin
                n_err++; $display("FAIL wrap[%0d] got=%h exp=%h", k, cur(), e);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        vec_t v[$];
        ifid_t e;
        drive(OP_NONE, 0);
        @(negedge i_clk);
        i_reset = 0;
        #1;
        e = E(0, 0, 0, 0, 0);
        n_cmp++;
        if (cur() !== e) begin
            n_err++; $display("FAIL reset_async got=%h exp=%h", cur(), e);
        end
        tick();
        i_reset = 1;
        v.push_back(vec_t'{OP_NONE,  32'h0, E(0, 0, 0, 0, 0)});
        v.push_back(vec_t'{OP_START, 32'h0, E(0, 0, 0, 0, 0)});
        v.push_back(vec_t'{OP_NONE,  32'h0, E(32'h2001_0005, 0, 4, 1, 0)});
        v.push_back(vec_t'{OP_NONE,  32'h0, E(32'h2002_0007, 4, 8, 1, 0)});
        v.push_back(vec_t'{OP_NONE,  32'h0, E(32'h2000_0002, 8, 32'hC, 1, 0)});
        for (int k = 0; k < v.size(); k++) begin
            drive(v[k].op, v[k].tgt); sb.push_back(v[k].e); tick();
            e = sb.pop_front(); n_cmp++;
            if (cur() !== e) begin
                n_err++; $display("FAIL reset_mid_run[%0d] got=%h exp=%h", k, cur(), e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 0;
        drive(OP_NONE, 0);
        repeat (3) @(posedge i_clk);
        #1;
        test_reset();
        test_load();
        test_halt_program();
        pulse_reset();
        write_word(2, 32'h2000_0002);
        test_branch();
        test_jump_vs_branch();
        test_stall();
        test_redirect_vs_halt();
        test_wrap();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
